// File: rtl/regfile_dump_reader.sv
// Read-only dump client for the 32x32 register file: walks an inclusive,
// wrap-around index range through the asynchronous read port and streams each word out.
module regfile_dump_reader #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [4:0]    first,
    input  logic [4:0]    last,
    input  logic          abort,
    output logic [4:0]    ra,
    input  logic [DW-1:0] busA,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [4:0]    out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int unsigned IW = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] end_q, end_d;
    logic [IW-1:0] ra_q, ra_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          handshake;
    logic [IW-1:0] idx_inc;

    assign handshake = out_valid_q & out_ready;
    assign idx_inc   = (idx_q == IW'(NREGS - 1)) ? '0 : idx_q + IW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over start and over a same-cycle handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (handshake) begin
                    state_d = out_last_q ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; ra is registered so it already equals idx in FETCH
    always_comb begin
        idx_d       = idx_q;
        end_d       = end_q;
        ra_d        = ra_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    idx_d = first;
                    end_d = last;
                    ra_d  = first;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    ra_d        = '0;
                end else begin
                    out_data_d  = busA;
                    out_idx_d   = idx_q;
                    out_last_d  = (idx_q == end_q);
                    out_valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    ra_d        = '0;
                end else if (handshake) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        done_d = 1'b1;
                        ra_d   = '0;
                    end else begin
                        idx_d = idx_inc;
                        ra_d  = idx_inc;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                ra_d        = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            end_q       <= '0;
            ra_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            end_q       <= end_d;
            ra_q        <= ra_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ra        = ra_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a behavioural register file plus a range model
// that predicts every beat, checked with immediate assertions.
module tb_regfile_dump_reader;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    first;
    logic [4:0]    last;
    logic          abort;
    logic [4:0]    ra;
    logic [DW-1:0] busA;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [4:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [32];
    int checks = 0;
    int errors = 0;

    assign busA = regs[ra];

    always #5 clk = ~clk;

    regfile_dump_reader #(.NREGS(32), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .first     (first),
        .last      (last),
        .abort     (abort),
        .ra        (ra),
        .busA      (busA),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ra"},    32'(ra),        32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"},  out_data,       32'd0);
        check({tag, "_idx"},   32'(out_idx),   32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = ready low 5 cycles per beat
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input int abort_beat, input int snap_beat);
        logic [4:0]    e_idx [$];
        logic [DW-1:0] e_dat [$];
        logic [4:0]    ix;
        logic [4:0]    span;
        int n, k, cyc, stall;
        bit fin, done_exp, rdy;
        span = l - f;
        n = int'(span) + 1;
        for (int i = 0; i < n; i++) begin
            ix = f + 5'(i);
            e_idx.push_back(ix);
            e_dat.push_back((ix == 5'd0) ? '0 : regs[ix]);
        end
        k = 0; cyc = 0; stall = 0; fin = 0; done_exp = 0;
        @(negedge clk);
        start = 1'b1; first = f; last = l; out_ready = 1'b0;
        while (!fin && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            first = 5'($urandom);
            last  = 5'($urandom);
            if (done_exp) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_after", 32'(busy), 32'd0);
                check("valid_after", 32'(out_valid), 32'd0);
                check("ra_idle", 32'(ra), 32'd0);
                if (mode == 0) check("done_latency", 32'(cyc), 32'(2 * n + 1));
                out_ready = 1'b0;
                @(negedge clk);
                check("done_one_cycle", 32'(done), 32'd0);
                fin = 1;
            end else begin
                check("busy", 32'(busy), 32'd1);
                check("no_early_done", 32'(done), 32'd0);
                if (out_valid) begin
                    check("beat_idx", 32'(out_idx), 32'(e_idx[k]));
                    check("beat_data", out_data, e_dat[k]);
                    check("beat_last", 32'(out_last), 32'(k == n - 1));
                    check("ra_send", 32'(ra), 32'(e_idx[k]));
                    if (snap_beat == k && stall == 0) regs[e_idx[k]] = 32'hAAAA0000;
                    if (abort_beat == k) begin
                        abort = 1'b1;
                        out_ready = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        out_ready = 1'b0;
                        check("abort_valid", 32'(out_valid), 32'd0);
                        check("abort_last", 32'(out_last), 32'd0);
                        check("abort_busy", 32'(busy), 32'd0);
                        check("abort_done", 32'(done), 32'd0);
                        @(negedge clk);
                        check("abort_no_done", 32'(done), 32'd0);
                        check("abort_idle_ra", 32'(ra), 32'd0);
                        fin = 1;
                    end else begin
                        case (mode)
                            0:       rdy = 1'b1;
                            1:       rdy = 1'($urandom_range(0, 1));
                            default: rdy = (stall >= 5);
                        endcase
                        out_ready = rdy;
                        if (rdy) begin
                            stall = 0;
                            k++;
                            if (k == n) done_exp = 1;
                        end else begin
                            stall++;
                            start = 1'($urandom_range(0, 1));
                        end
                    end
                end else begin
                    check("ra_fetch", 32'(ra), 32'(e_idx[k]));
                    out_ready = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $error("FAIL dump_timeout observed_beats=%0d expected_beats=%0d", k, n);
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rf, rl;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        first = '0; last = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : $urandom;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a stalled SEND
        regs[5] = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b1; first = 5'd5; last = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        check("pre_reset_data", out_data, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(5'd5, 5'd9, 0, -1, -1);

        // Single word
        regs[7] = 32'h12345678;
        run_dump(5'd7, 5'd7, 0, -1, -1);

        // Full wrap, all 32 registers
        for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;
        run_dump(5'd30, 5'd29, 0, -1, -1);

        // Backpressure with ignored starts
        run_dump(5'd2, 5'd4, 2, -1, -1);

        // Snapshot: write lands while the word is stalled
        regs[3] = 32'h11111111;
        run_dump(5'd3, 5'd3, 2, -1, 0);
        check("snap_regfile_written", regs[3], 32'hAAAA0000);

        // Abort on the 4th beat
        run_dump(5'd0, 5'd31, 0, 3, -1);

        // Abort while idle blocks a start
        @(negedge clk);
        start = 1'b1; abort = 1'b1; first = 5'd4; last = 5'd6;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_ra", 32'(ra), 32'd0);

        // Randomized dumps
        for (int t = 0; t < 8; t++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            rf = 5'($urandom);
            rl = rf + 5'($urandom_range(0, 9));
            run_dump(rf, rl, (t % 2 == 0) ? 1 : 0, (t == 5) ? 1 : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
